// File: rtl/usb2_phy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : usb2_phy_pkg                                                     |
// | Brief   : Shared types and default timing for the USB 2.0 PHY reset and   |
// |           chirp logic (host side): FSM state encoding, pad/status bundle, |
// |           48 MHz default counts and the state-to-output decode.           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+

`ifndef USB2_TIMER_WIDTH
`define USB2_TIMER_WIDTH 24
`endif

package usb2_phy_pkg;

  localparam int c_timer_width = `USB2_TIMER_WIDTH;

  // Default counts for a 48 MHz clock.
  localparam int c_attach_db_clks = 4800000;  // 100 ms
  localparam int c_reset_len_clks = 480000;   // 10 ms
  localparam int c_dev_k_det_clks = 120;      // 2.5 us
  localparam int c_kj_len_clks    = 2400;     // 50 us
  localparam int c_min_kj_pairs   = 3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'h0,
    ST_ATTACH_DB = 4'h1,
    ST_RESET_SE0 = 4'h2,
    ST_DEV_K_END = 4'h3,
    ST_HOST_K    = 4'h4,
    ST_HOST_J    = 4'h5,
    ST_HS_DONE   = 4'h6,
    ST_FS_DONE   = 4'h7
  } host_chirp_state_t;

  typedef struct packed {
    logic dp_drive;
    logic dn_drive;
    logic dp_oe;
    logic dn_oe;
    logic reset_active;
    logic reset_done;
    logic hs_mode;
    logic fs_mode;
  } host_pad_out_t;

  // Moore decode of the pad controls and status flags for a given state.
  function automatic host_pad_out_t host_chirp_outputs(input host_chirp_state_t st);
    host_pad_out_t o;
    o = '0;
    case (st)
      ST_RESET_SE0: begin
        o.dp_oe = 1'b1; o.dn_oe = 1'b1; o.reset_active = 1'b1;
      end
      ST_DEV_K_END: o.reset_active = 1'b1;
      ST_HOST_K: begin
        o.dp_oe = 1'b1; o.dn_oe = 1'b1; o.dn_drive = 1'b1; o.reset_active = 1'b1;
      end
      ST_HOST_J: begin
        o.dp_oe = 1'b1; o.dn_oe = 1'b1; o.dp_drive = 1'b1; o.reset_active = 1'b1;
      end
      ST_HS_DONE: begin
        o.hs_mode = 1'b1; o.reset_done = 1'b1;
      end
      ST_FS_DONE: begin
        o.fs_mode = 1'b1; o.reset_done = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // States during which the total bus-reset time accumulates.
  function automatic logic in_reset_window(input host_chirp_state_t st);
    return (st == ST_RESET_SE0) || (st == ST_DEV_K_END) ||
           (st == ST_HOST_K)    || (st == ST_HOST_J);
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb2_host_reset_chirp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : usb2_host_reset_chirp_if                                       |
// | Brief     : Port-control, line-state and pad-control bundle of the host   |
// |             reset/chirp block.                                            |
// |   master : the reset/chirp controller (reads line state, drives pads)     |
// |   slave  : the port/line side (drives line state, reads pads/status)      |
// |   i_port_en, i_hs_enable      port control                                |
// |   i_se0, i_j_state, i_k_state synchronised line state                     |
// |   o_dp/dn_drive, o_dp/dn_oe   pad controls                                |
// |   o_reset_active/done, o_hs_mode, o_fs_mode, o_kj_pairs, o_state status   |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+

interface usb2_host_reset_chirp_if;
  logic       i_port_en;
  logic       i_hs_enable;
  logic       i_se0;
  logic       i_j_state;
  logic       i_k_state;
  logic       o_dp_drive;
  logic       o_dn_drive;
  logic       o_dp_oe;
  logic       o_dn_oe;
  logic       o_reset_active;
  logic       o_reset_done;
  logic       o_hs_mode;
  logic       o_fs_mode;
  logic [3:0] o_kj_pairs;
  logic [3:0] o_state;

  modport master (
    input  i_port_en, i_hs_enable, i_se0, i_j_state, i_k_state,
    output o_dp_drive, o_dn_drive, o_dp_oe, o_dn_oe,
           o_reset_active, o_reset_done, o_hs_mode, o_fs_mode,
           o_kj_pairs, o_state
  );

  modport slave (
    output i_port_en, i_hs_enable, i_se0, i_j_state, i_k_state,
    input  o_dp_drive, o_dn_drive, o_dp_oe, o_dn_oe,
           o_reset_active, o_reset_done, o_hs_mode, o_fs_mode,
           o_kj_pairs, o_state
  );
endinterface

`default_nettype wire

// File: rtl/usb2_sat_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : usb2_sat_timer                                                    |
// | Brief  : Free-running up-counter that saturates at all-ones.              |
// |   i_clk, i_rst_n : clock, asynchronous active-low reset                   |
// |   i_clear        : synchronous clear (wins over i_enable)                 |
// |   i_enable       : count enable                                            |
// |   o_count        : current count                                           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+

module usb2_sat_timer #(
  parameter int WIDTH = `USB2_TIMER_WIDTH
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  input  wire logic             i_clear,
  input  wire logic             i_enable,
  output logic      [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + c_one;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/usb2_host_reset_chirp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : usb2_host_reset_chirp                                             |
// | Brief  : Downstream-port side of USB 2.0 bus reset and HS handshake.      |
// |          Debounces attach, drives SE0, qualifies the device Chirp K,     |
// |          answers with host K/J chirps and ends in HS or FS mode.         |
// |   i_clk, i_rst_n : 48 MHz clock, asynchronous active-low reset            |
// |   port_if        : control/line-state/pad bundle (master modport)         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+

module usb2_host_reset_chirp
  import usb2_phy_pkg::*;
#(
  parameter int P_ATTACH_DB = c_attach_db_clks,
  parameter int P_RESET_LEN = c_reset_len_clks,
  parameter int P_DEV_K_DET = c_dev_k_det_clks,
  parameter int P_KJ_LEN    = c_kj_len_clks,
  parameter int P_MIN_PAIRS = c_min_kj_pairs
) (
  input wire logic              i_clk,
  input wire logic              i_rst_n,
  usb2_host_reset_chirp_if.master port_if
);

  localparam int TW = c_timer_width;

  localparam logic [TW-1:0] c_adb_last  = TW'(P_ATTACH_DB - 1);
  localparam logic [TW-1:0] c_rst_last  = TW'(P_RESET_LEN - 1);
  localparam logic [TW-1:0] c_kdet_last = TW'(P_DEV_K_DET - 1);
  localparam logic [TW-1:0] c_kj_last   = TW'(P_KJ_LEN - 1);
  localparam logic [TW-1:0] c_one       = TW'(1);
  localparam logic [3:0]    c_min_pairs = 4'(P_MIN_PAIRS);

  host_chirp_state_t r_state;
  host_chirp_state_t w_state_nxt;
  host_pad_out_t     r_pads;
  logic [3:0]        r_kj_pairs;
  logic [TW-1:0]     r_k_run;
  logic [TW-1:0]     w_phase;
  logic [TW-1:0]     w_rst;

  // Line-state decode with se0 > k > j priority.
  logic w_se0, w_k, w_j;
  assign w_se0 = port_if.i_se0;
  assign w_k   = port_if.i_k_state & ~port_if.i_se0;
  assign w_j   = port_if.i_j_state & ~port_if.i_se0 & ~port_if.i_k_state;

  logic       w_pair_end;
  logic [3:0] w_pairs_inc;
  assign w_pair_end  = (r_state == ST_HOST_J) && (w_phase == c_kj_last);
  assign w_pairs_inc = (r_kj_pairs == 4'hF) ? 4'hF : r_kj_pairs + 4'd1;

  // phase_tmr restarts whenever the state is about to change, so it always
  // reads "clocks spent in the current state".
  usb2_sat_timer #(.WIDTH(TW)) u_phase_tmr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_state_nxt != r_state),
    .i_enable (1'b1),
    .o_count  (w_phase)
  );

  // rst_tmr measures total time since SE0 started, across the chirp states.
  usb2_sat_timer #(.WIDTH(TW)) u_rst_tmr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (!in_reset_window(r_state)),
    .i_enable (1'b1),
    .o_count  (w_rst)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (!port_if.i_port_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:
          if (w_j) w_state_nxt = ST_ATTACH_DB;
        ST_ATTACH_DB:
          if (!w_j)                      w_state_nxt = ST_IDLE;
          else if (w_phase == c_adb_last) w_state_nxt = ST_RESET_SE0;
        ST_RESET_SE0:
          // The current K clock completes the run: k_run holds the previous
          // consecutive count, so a run of exactly P_DEV_K_DET qualifies.
          if (port_if.i_hs_enable && w_k && (r_k_run == c_kdet_last))
            w_state_nxt = ST_DEV_K_END;
          else if (w_rst == c_rst_last)
            w_state_nxt = ST_FS_DONE;
        ST_DEV_K_END:
          if (w_se0)                   w_state_nxt = ST_HOST_K;
          else if (w_rst >= c_rst_last) w_state_nxt = ST_FS_DONE;
        ST_HOST_K:
          if (w_phase == c_kj_last) w_state_nxt = ST_HOST_J;
        ST_HOST_J:
          if (w_pair_end) begin
            if ((w_rst >= c_rst_last) && (w_pairs_inc >= c_min_pairs))
              w_state_nxt = ST_HS_DONE;
            else
              w_state_nxt = ST_HOST_K;
          end
        ST_HS_DONE: w_state_nxt = ST_HS_DONE;
        ST_FS_DONE: w_state_nxt = ST_FS_DONE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Pads and status are decoded from the present state and registered, so
  // they follow a state change by one clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_pads     <= '0;
      r_kj_pairs <= '0;
      r_k_run    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pads  <= host_chirp_outputs(r_state);

      if (r_state == ST_IDLE)
        r_kj_pairs <= '0;
      else if (w_pair_end && port_if.i_port_en)
        r_kj_pairs <= w_pairs_inc;

      if ((r_state == ST_RESET_SE0) && w_k) begin
        if (r_k_run != '1) r_k_run <= r_k_run + c_one;
      end else begin
        r_k_run <= '0;
      end
    end
  end

  assign port_if.o_dp_drive     = r_pads.dp_drive;
  assign port_if.o_dn_drive     = r_pads.dn_drive;
  assign port_if.o_dp_oe        = r_pads.dp_oe;
  assign port_if.o_dn_oe        = r_pads.dn_oe;
  assign port_if.o_reset_active = r_pads.reset_active;
  assign port_if.o_reset_done   = r_pads.reset_done;
  assign port_if.o_hs_mode      = r_pads.hs_mode;
  assign port_if.o_fs_mode      = r_pads.fs_mode;
  assign port_if.o_kj_pairs     = r_kj_pairs;
  assign port_if.o_state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_usb2_host_reset_chirp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_usb2_host_reset_chirp                                          |
// | Brief  : Self-checking bench for usb2_host_reset_chirp with scaled timing |
// |          (attach 20, reset 300, K qualify 12, chirp 16, 3 pairs).         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+

module tb_usb2_host_reset_chirp;

  localparam int ADB  = 20;
  localparam int RL   = 300;
  localparam int KDET = 12;
  localparam int KJ   = 16;
  localparam int MINP = 3;
  localparam int SLEN = 512;

  localparam logic [2:0] L_SE0 = 3'b100;  // {se0, j, k}
  localparam logic [2:0] L_J   = 3'b010;
  localparam logic [2:0] L_K   = 3'b001;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  usb2_host_reset_chirp_if port_if ();

  usb2_host_reset_chirp #(
    .P_ATTACH_DB (ADB),
    .P_RESET_LEN (RL),
    .P_DEV_K_DET (KDET),
    .P_KJ_LEN    (KJ),
    .P_MIN_PAIRS (MINP)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .port_if (port_if)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] stim [SLEN];
  bit m_hs;
  int m_d, m_h, m_done, m_pairs;
  int obs_done, obs_ra;

  typedef struct {
    bit hs_en;
    bit pulses;
    int k_start;
    int k_len;
    bit exp_hs;
    int exp_pairs;
    int exp_done;
  } row_t;
  row_t rows [8];

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic set_line(input logic [2:0] l);
    port_if.i_se0     = l[2];
    port_if.i_j_state = l[1];
    port_if.i_k_state = l[0];
  endtask

  function automatic logic [2:0] line_at(input int c);
    return (c >= 0 && c < SLEN) ? stim[c] : L_SE0;
  endfunction

  function automatic bit is_k(input logic [2:0] l);
    return l[0] && !l[2];
  endfunction

  function automatic logic [15:0] snap();
    return {port_if.o_state, port_if.o_dp_drive, port_if.o_dn_drive,
            port_if.o_dp_oe, port_if.o_dn_oe, port_if.o_reset_active,
            port_if.o_reset_done, port_if.o_hs_mode, port_if.o_fs_mode,
            port_if.o_kj_pairs};
  endfunction

  // Reference model. Cycle 0 is the first clock spent driving SE0; the line
  // value of cycle c is sampled at the edge that ends cycle c, and the reset
  // timer reads c during cycle c.
  task automatic run_model(input bit hs_en);
    int run;
    int n;
    logic [2:0] l;
    run = 0; m_d = -1; m_h = -1; m_hs = 0; m_pairs = 0; m_done = RL;
    if (hs_en) begin
      for (int c = 0; c < RL; c++) begin
        if (is_k(line_at(c))) run++; else run = 0;
        if (run >= KDET) begin m_d = c + 1; break; end
      end
    end
    if (m_d >= 0) begin
      for (int c = m_d; c < SLEN + RL; c++) begin
        l = line_at(c);
        if (l[2])        begin m_h = c + 1;    break; end
        if (c >= RL - 1) begin m_done = c + 1; break; end
      end
      if (m_h >= 0) begin
        m_hs = 1;
        n = MINP;
        while (m_h + 2 * KJ * n - 1 < RL - 1) n++;
        m_done  = m_h + 2 * KJ * n;
        m_pairs = (n > 15) ? 15 : n;
      end
    end
  endtask

  function automatic logic [3:0] exp_state(input int c);
    if (c < -ADB) return 4'h0;
    if (c < 0)    return 4'h1;
    if (m_d < 0)  return (c < RL) ? 4'h2 : 4'h7;
    if (c < m_d)  return 4'h2;
    if (!m_hs)    return (c < m_done) ? 4'h3 : 4'h7;
    if (c < m_h)  return 4'h3;
    if (c < m_done) return (((c - m_h) / KJ) % 2 == 1) ? 4'h5 : 4'h4;
    return 4'h6;
  endfunction

  // {dp, dn, dp_oe, dn_oe, reset_active, reset_done, hs, fs}
  function automatic logic [7:0] exp_pads(input logic [3:0] st);
    case (st)
      4'h2:    return 8'b0011_1000;
      4'h3:    return 8'b0000_1000;
      4'h4:    return 8'b0111_1000;
      4'h5:    return 8'b1011_1000;
      4'h6:    return 8'b0000_0110;
      4'h7:    return 8'b0000_0101;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [3:0] exp_kj(input int c);
    if (!m_hs || c < m_h) return 4'h0;
    if (c < m_done)       return 4'((c - m_h) / (2 * KJ));
    return 4'(m_pairs);
  endfunction

  task automatic go_idle();
    @(negedge i_clk);
    port_if.i_port_en = 1'b0;
    set_line(L_SE0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("idle", 0, 32'(snap()), 32'h0);
  endtask

  // Attach, reset and chirp episode; stops after stop_c (or done+3 if < 0).
  task automatic run_episode(input bit hs_en, input int stop_c);
    int last;
    go_idle();
    port_if.i_hs_enable = hs_en;
    port_if.i_port_en   = 1'b1;
    set_line(L_J);
    obs_done = -1;
    obs_ra   = 0;
    last = (stop_c >= 0) ? stop_c : m_done + 3;
    for (int c = -ADB; c <= last; c++) begin
      @(negedge i_clk);
      check("cycle", c, 32'(snap()),
            32'({exp_state(c), exp_pads(exp_state(c - 1)), exp_kj(c)}));
      if (obs_done < 0 && (port_if.o_state == 4'h6 || port_if.o_state == 4'h7))
        obs_done = c;
      if (port_if.o_reset_active) obs_ra++;
      set_line((c < 0) ? L_J : line_at(c));
    end
  endtask

  task automatic build_row(input row_t r);
    for (int c = 0; c < SLEN; c++) begin
      if (r.pulses)
        stim[c] = ((c % KDET) < KDET - 1) ? L_K : L_SE0;
      else
        stim[c] = (c >= r.k_start && c < r.k_start + r.k_len) ? L_K : L_SE0;
    end
  endtask

  task automatic build_random();
    int c;
    int len;
    logic [2:0] l;
    c = 0;
    len = $urandom_range(0, 310);
    for (int i = 0; i < len && c < SLEN; i++) begin stim[c] = L_SE0; c++; end
    while (c < SLEN) begin
      if ($urandom_range(0, 1) == 1) begin
        len = $urandom_range(1, KDET + 6);
        for (int i = 0; i < len && c < SLEN; i++) begin
          l = {1'b0, 1'($urandom_range(0, 1)), 1'b1};
          stim[c] = l; c++;
        end
      end else begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len && c < SLEN; i++) begin
          l = 3'($urandom_range(0, 7));
          stim[c] = l; c++;
        end
      end
    end
  endtask

  initial begin
    // hs_en, pulses, k_start, k_len, exp_hs, exp_pairs, exp_done
    rows[0] = '{1'b1, 1'b0, 0,   0,  1'b0, 0, 300};  // no chirp: FS
    rows[1] = '{1'b1, 1'b0, 10,  40, 1'b1, 8, 307};  // normal HS
    rows[2] = '{1'b1, 1'b1, 0,   0,  1'b0, 0, 300};  // 11-clock K pulses
    rows[3] = '{1'b0, 1'b0, 10,  20, 1'b0, 0, 300};  // HS disabled
    rows[4] = '{1'b1, 1'b0, 288, 40, 1'b0, 0, 301};  // K qualifies on last reset clock
    rows[5] = '{1'b1, 1'b0, 289, 40, 1'b0, 0, 300};  // K qualifies one clock too late
    rows[6] = '{1'b1, 1'b0, 250, 30, 1'b1, 3, 377};  // minimum pair count governs
    rows[7] = '{1'b1, 1'b0, 180, 23, 1'b1, 3, 300};  // reset time met exactly at J end

    port_if.i_port_en   = 1'b0;
    port_if.i_hs_enable = 1'b0;
    set_line(L_SE0);
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_state", 0, 32'(snap()), 32'h0);
    i_rst_n = 1'b1;

    // Attach glitch: one non-J clock during debounce returns to IDLE.
    go_idle();
    port_if.i_hs_enable = 1'b1;
    port_if.i_port_en   = 1'b1;
    set_line(L_J);
    repeat (8) @(negedge i_clk);
    check("attach_db", 0, 32'(port_if.o_state), 32'h1);
    set_line(L_SE0);
    @(negedge i_clk);
    check("glitch_idle", 0, 32'(port_if.o_state), 32'h0);
    set_line(L_J);
    @(negedge i_clk);
    check("reattach", 0, 32'(port_if.o_state), 32'h1);

    for (int i = 0; i < 8; i++) begin
      build_row(rows[i]);
      run_model(rows[i].hs_en);
      run_episode(rows[i].hs_en, -1);
      check("done_cycle", i, 32'(obs_done), 32'(rows[i].exp_done));
      check("reset_len", i, 32'(obs_ra), 32'(rows[i].exp_done));
      check("hs_mode", i, 32'(port_if.o_hs_mode), 32'(rows[i].exp_hs));
      check("fs_mode", i, 32'(port_if.o_fs_mode), 32'(!rows[i].exp_hs));
      check("kj_pairs", i, 32'(port_if.o_kj_pairs), 32'(rows[i].exp_pairs));
    end

    // Abort in the third host K: IDLE next clock, pads/pairs clear after.
    build_row(rows[1]);
    run_model(1'b1);
    run_episode(1'b1, 120);
    port_if.i_port_en = 1'b0;
    @(negedge i_clk);
    check("abort_state", 0, 32'(port_if.o_state), 32'h0);
    @(negedge i_clk);
    check("abort_outs", 0, 32'(snap()), 32'h0);

    // Asynchronous reset in a host J, checked before any clock edge.
    build_row(rows[1]);
    run_model(1'b1);
    run_episode(1'b1, 140);
    #2 i_rst_n = 1'b0;
    #1 check("async_rst", 0, 32'(snap()), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      bit hs_en;
      hs_en = ($urandom_range(0, 4) != 0);
      build_random();
      run_model(hs_en);
      run_episode(hs_en, -1);
      check("rnd_done", i, 32'(obs_done), 32'(m_done));
      check("rnd_reset_len", i, 32'(obs_ra), 32'(m_done));
      check("rnd_kj_pairs", i, 32'(port_if.o_kj_pairs), 32'(m_pairs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
